// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA sync/DE generator with a latency-matched
// pixel-request pipeline and frame-synchronous test patterns.
// Ports: clk25MHz pixel clock, rst async active-low reset;
//   mode/solid_rgb select the pattern, sampled per frame (solid_rgb is live);
//   pix_req/pix_x/pix_y request a pixel, pix_in returns PIX_LAT clocks later;
//   hsync/vsync/de/rgb/frame_start/line_start are aligned outputs.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FPORCH = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BPORCH = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FPORCH = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BPORCH = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 11,
    parameter int   PIX_LAT  = 2,
    parameter int   RGB_W    = 8
) (
    input  logic             clk25MHz,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic             pix_req,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    input  logic [RGB_W-1:0] pix_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FPORCH);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FPORCH + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FPORCH);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FPORCH + V_SYNC);

    // Bar colour field split {R,G,B}, MSB first; gives 3-3-2 at RGB_W = 8.
    // For other widths each field is all-ones or zero.
    localparam int BW = RGB_W / 3;
    localparam int RW = (RGB_W - BW) / 2;
    localparam int GW = RGB_W - BW - RW;

    // Bundle carried down the alignment pipeline.
    localparam int PW = 10;

    logic [CW-1:0]    r_hcnt;
    logic [CW-1:0]    r_vcnt;
    logic [1:0]       r_mode;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic             r_fs;
    logic             r_ls;

    logic             w_hact;
    logic             w_vact;
    logic             w_req;
    logic             w_hs0;
    logic             w_vs0;
    logic             w_origin;
    logic             w_fs0;
    logic             w_ls0;
    logic [1:0]       w_mode0;
    logic [2:0]       w_bar0;
    logic [PW-1:0]    w_s0;
    logic [PW-1:0]    w_sn;
    logic             w_hsn;
    logic             w_vsn;
    logic             w_den;
    logic             w_fsn;
    logic             w_lsn;
    logic [1:0]       w_moden;
    logic [2:0]       w_barn;
    logic [RGB_W-1:0] w_pix;

    function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
        logic [2:0]       c;
        logic [RGB_W-1:0] o;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        for (int i = 0; i < RGB_W; i++) begin
            if (i < BW)           o[i] = c[0];
            else if (i < BW + GW) o[i] = c[1];
            else                  o[i] = c[2];
        end
        return o;
    endfunction

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign w_hact   = r_hcnt < H_ACT;
    assign w_vact   = r_vcnt < V_ACT;
    assign w_req    = w_hact && w_vact;
    assign w_hs0    = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
    assign w_vs0    = (r_vcnt >= V_SS) && (r_vcnt < V_SE);
    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_fs0    = w_req && w_origin;
    assign w_ls0    = w_req && (r_hcnt == '0);

    assign pix_req  = w_req;
    assign pix_x    = w_req ? r_hcnt : '0;
    assign pix_y    = w_req ? r_vcnt : '0;

    // The origin pixel uses the live mode so the whole frame agrees
    // with the value captured into r_mode on that same clock.
    assign w_mode0  = w_origin ? mode : r_mode;

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_mode <= 2'd0;
        end else if (w_origin) begin
            r_mode <= mode;
        end
    end

    // Bar index by threshold compare chain instead of a divider.
    always_comb begin
        w_bar0 = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_hcnt >= CW'(k * H_ACTIVE / 8)) begin
                w_bar0 = 3'(k);
            end
        end
    end

    assign w_s0 = {w_hs0, w_vs0, w_req, w_fs0, w_ls0, w_mode0, w_bar0};

    generate
        if (PIX_LAT == 0) begin : g_nolat
            assign w_sn = w_s0;
        end else begin : g_lat
            logic [PW-1:0] r_dly [PIX_LAT];
            always_ff @(posedge clk25MHz or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= w_s0;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_sn = r_dly[PIX_LAT-1];
        end
    endgenerate

    assign {w_hsn, w_vsn, w_den, w_fsn, w_lsn, w_moden, w_barn} = w_sn;

    always_comb begin
        w_pix = '0;
        if (w_den) begin
            case (w_moden)
                2'd0:    w_pix = pix_in;
                2'd1:    w_pix = bar_rgb(w_barn);
                2'd2:    w_pix = solid_rgb;
                default: w_pix = '0;
            endcase
        end
    end

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_rgb   <= '0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            r_hsync <= w_hsn ? H_POL : ~H_POL;
            r_vsync <= w_vsn ? V_POL : ~V_POL;
            r_de    <= w_den;
            r_rgb   <= w_pix;
            r_fs    <= w_fsn;
            r_ls    <= w_lsn;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign rgb         = r_rgb;
    assign frame_start = r_fs;
    assign line_start  = r_ls;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen, one default
// instance and one small active-high instance with PIX_LAT = 0.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lat;
    } cfg_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       ls;
        logic [7:0] rgb;
    } out_t;

    typedef struct packed {
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
    } s0_t;

    localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
    localparam cfg_t C1 = '{64, 4, 8, 4, 16, 2, 2, 3, 1, 1, 0};

    bit          clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  solid_rgb;
    logic        req [2];
    logic [10:0] px  [2];
    logic [10:0] py  [2];
    logic [7:0]  pin [2];
    logic        hs  [2];
    logic        vs  [2];
    logic        de  [2];
    logic [7:0]  rgb [2];
    logic        fs  [2];
    logic        ls  [2];

    out_t qo0 [$];
    out_t qo1 [$];
    s0_t  qs0 [$];
    s0_t  qs1 [$];
    s0_t  src0 [$];
    s0_t  src1 [$];

    int         n_chk  = 0;
    int         n_fail = 0;
    int         p [2];
    logic [1:0] fmode [2];
    bit         in_rst;
    logic [7:0] seed8;

    int agg_seen, agg_cyc, agg_vs, agg_de;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk25MHz    (clk),
        .rst         (rst),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .pix_req     (req[0]),
        .pix_x       (px[0]),
        .pix_y       (py[0]),
        .pix_in      (pin[0]),
        .hsync       (hs[0]),
        .vsync       (vs[0]),
        .de          (de[0]),
        .rgb         (rgb[0]),
        .frame_start (fs[0]),
        .line_start  (ls[0])
    );

    vga_timing_gen #(
        .H_ACTIVE (64), .H_FPORCH (4), .H_SYNC (8), .H_BPORCH (4),
        .V_ACTIVE (16), .V_FPORCH (2), .V_SYNC (2), .V_BPORCH (3),
        .H_POL (1'b1), .V_POL (1'b1), .CW (11), .PIX_LAT (0), .RGB_W (8)
    ) u_sml (
        .clk25MHz    (clk),
        .rst         (rst),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .pix_req     (req[1]),
        .pix_x       (px[1]),
        .pix_y       (py[1]),
        .pix_in      (pin[1]),
        .hsync       (hs[1]),
        .vsync       (vs[1]),
        .de          (de[1]),
        .rgb         (rgb[1]),
        .frame_start (fs[1]),
        .line_start  (ls[1])
    );

    function automatic cfg_t cf(int i);
        return (i == 0) ? C0 : C1;
    endfunction

    function automatic int htot(int i);
        cfg_t c = cf(i);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(int i);
        cfg_t c = cf(i);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    function automatic logic [7:0] pixv(int x, int y);
        return 8'(x + 3 * y) ^ seed8;
    endfunction

    function automatic logic [7:0] bar(int k);
        case (k)
            0:       return 8'hFF;
            1:       return 8'hFC;
            2:       return 8'h1F;
            3:       return 8'h1C;
            4:       return 8'hE3;
            5:       return 8'hE0;
            6:       return 8'h03;
            default: return 8'h00;
        endcase
    endfunction

    function automatic out_t rst_out(int i);
        cfg_t c = cf(i);
        out_t o;
        o     = '0;
        o.hs  = !1'(c.hp);
        o.vs  = !1'(c.vp);
        return o;
    endfunction

    // Expected aligned outputs for a stage-0 position pp clocks after release.
    function automatic out_t model_out(int i, int pp, logic [1:0] md);
        cfg_t c = cf(i);
        int   h = pp % htot(i);
        int   v = (pp / htot(i)) % vtot(i);
        bit   act;
        out_t o;
        act   = (h < c.ha) && (v < c.va);
        o.hs  = ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs)) ?
                1'(c.hp) : !1'(c.hp);
        o.vs  = ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs)) ?
                1'(c.vp) : !1'(c.vp);
        o.de  = act;
        o.fs  = act && (h == 0) && (v == 0);
        o.ls  = act && (h == 0);
        o.rgb = 8'h00;
        if (act) begin
            case (md)
                2'd0:    o.rgb = pixv(h, v);
                2'd1:    o.rgb = bar(h * 8 / c.ha);
                2'd2:    o.rgb = solid_rgb;
                default: o.rgb = 8'h00;
            endcase
        end
        return o;
    endfunction

    function automatic s0_t model_s0(int i, int pp);
        cfg_t c = cf(i);
        int   h = pp % htot(i);
        int   v = (pp / htot(i)) % vtot(i);
        s0_t  s;
        s.req = (h < c.ha) && (v < c.va);
        s.x   = s.req ? 11'(h) : 11'd0;
        s.y   = s.req ? 11'(v) : 11'd0;
        return s;
    endfunction

    task automatic push_o(int i, out_t o);
        if (i == 0) qo0.push_back(o);
        else        qo1.push_back(o);
    endtask

    task automatic push_s(int i, s0_t s);
        if (i == 0) qs0.push_back(s);
        else        qs1.push_back(s);
    endtask

    // One clock of stimulus: drive reset/mode, queue expectations,
    // then act as the latency-PIX_LAT pixel source for each instance.
    task automatic step(input bit nrst, input logic [1:0] md);
        s0_t s;
        @(posedge clk);
        #1;
        mode = md;
        if (!nrst) begin
            rst = 1'b0;
            qo0.delete(); qo1.delete(); qs0.delete(); qs1.delete();
            for (int i = 0; i < 2; i++) begin
                push_o(i, rst_out(i));
                push_s(i, model_s0(i, 0));
                p[i] = 0;
            end
            in_rst = 1'b1;
        end else begin
            rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (in_rst) begin
                    for (int k = 0; k <= cf(i).lat; k++) push_o(i, rst_out(i));
                end
                if (p[i] % (htot(i) * vtot(i)) == 0) fmode[i] = md;
                push_o(i, model_out(i, p[i], fmode[i]));
                push_s(i, model_s0(i, p[i]));
                p[i]++;
            end
            in_rst = 1'b0;
        end
        #1;
        if (!rst) begin
            src0.delete(); src1.delete();
            pin[0] = 8'($urandom);
            pin[1] = 8'($urandom);
        end else begin
            src0.push_back('{req[0], px[0], py[0]});
            src1.push_back('{req[1], px[1], py[1]});
            pin[0] = 8'($urandom);
            pin[1] = 8'($urandom);
            if (src0.size() > C0.lat) begin
                s = src0.pop_front();
                if (s.req) pin[0] = pixv(int'(s.x), int'(s.y));
            end
            if (src1.size() > C1.lat) begin
                s = src1.pop_front();
                if (s.req) pin[1] = pixv(int'(s.x), int'(s.y));
            end
        end
    endtask

    task automatic run(int n);
        logic [1:0] md;
        for (int k = 0; k < n; k++) begin
            md = mode;
            if ($urandom_range(0, 399) == 0) md = 2'($urandom_range(0, 3));
            step(1'b1, md);
        end
    endtask

    always @(negedge clk) begin : mon
        out_t eo, ao;
        s0_t  es, as;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            ok = 1'b1;
            if (i == 0) begin
                if (qo0.size() == 0 || qs0.size() == 0) ok = 1'b0;
                else begin eo = qo0.pop_front(); es = qs0.pop_front(); end
            end else begin
                if (qo1.size() == 0 || qs1.size() == 0) ok = 1'b0;
                else begin eo = qo1.pop_front(); es = qs1.pop_front(); end
            end
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL queue_empty inst%0d t=%0t", i, $time);
            end else begin
                ao = {hs[i], vs[i], de[i], fs[i], ls[i], rgb[i]};
                as = {req[i], px[i], py[i]};
                if (ao !== eo) begin
                    n_fail++;
                    $display("FAIL out inst%0d t=%0t got %h expected %h (hs,vs,de,fs,ls,rgb)",
                             i, $time, ao, eo);
                end
                n_chk++;
                if (as !== es) begin
                    n_fail++;
                    $display("FAIL req inst%0d t=%0t got %h expected %h (req,x,y)",
                             i, $time, as, es);
                end
            end
        end
        // Whole-frame totals on the small instance between frame_start pulses.
        if (!rst) begin
            agg_seen = 0;
        end else if (fs[1]) begin
            if (agg_seen != 0) begin
                n_chk += 3;
                if (agg_cyc != htot(1) * vtot(1)) begin
                    n_fail++;
                    $display("FAIL frame_period got %0d expected %0d",
                             agg_cyc, htot(1) * vtot(1));
                end
                if (agg_vs != C1.vs * htot(1)) begin
                    n_fail++;
                    $display("FAIL vsync_clocks got %0d expected %0d",
                             agg_vs, C1.vs * htot(1));
                end
                if (agg_de != C1.ha * C1.va) begin
                    n_fail++;
                    $display("FAIL de_clocks got %0d expected %0d",
                             agg_de, C1.ha * C1.va);
                end
            end
            agg_seen = 1;
            agg_cyc  = 1;
            agg_vs   = int'(vs[1]);
            agg_de   = int'(de[1]);
        end else begin
            agg_cyc++;
            agg_vs += int'(vs[1]);
            agg_de += int'(de[1]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        mode      = 2'd1;
        solid_rgb = 8'h5A;
        seed8     = 8'($urandom);
        pin[0]    = 8'h00;
        pin[1]    = 8'h00;
        in_rst    = 1'b1;
        agg_seen  = 0;
        agg_cyc   = 0;
        agg_vs    = 0;
        agg_de    = 0;
        fmode[0]  = 2'd0;
        fmode[1]  = 2'd0;
        p[0]      = 0;
        p[1]      = 0;

        for (int k = 0; k < 4; k++) step(1'b0, 2'd1);
        run(7400);

        for (int k = 0; k < 2000; k++) begin
            if ((p[1] % htot(1) == 30) && ((p[1] / htot(1)) % vtot(1) == 10)) break;
            step(1'b1, mode);
        end

        solid_rgb = 8'($urandom);
        for (int k = 0; k < 5; k++) step(1'b0, 2'd0);
        run(4000);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
